// File: rtl/apb_regfile_slave.sv
// APB4 completer: bank of byte-strobed RW registers plus hardware-driven RO slots,
// with fixed wait states and slverr on range, alignment, RO-write and protection faults.
module apb_regfile_slave #(
  parameter int unsigned       DATA_W      = 32,
  parameter int unsigned       ADDR_W      = 32,
  parameter int unsigned       NUM_REGS    = 16,
  parameter int unsigned       NUM_RO      = 4,
  parameter int unsigned       WAIT_CYCLES = 0,
  parameter int unsigned       PROT_CHECK  = 0,
  parameter logic [DATA_W-1:0] RESET_VAL   = '0
) (
  input  logic                                          clk,
  input  logic                                          nrst,
  input  logic [ADDR_W-1:0]                             paddr,
  input  logic [2:0]                                    prot,
  input  logic                                          psel,
  input  logic                                          penable,
  input  logic                                          pwrite,
  input  logic [DATA_W-1:0]                             pwdata,
  input  logic [DATA_W/8-1:0]                           pstrb,
  output logic                                          pready,
  output logic [DATA_W-1:0]                             prdata,
  output logic                                          slverr,
  input  logic [((NUM_RO > 0) ? NUM_RO : 1)*DATA_W-1:0] ro_data,
  output logic [(NUM_REGS-NUM_RO)*DATA_W-1:0]           reg_out
);

  localparam int unsigned STRB_W = DATA_W / 8;
  localparam int unsigned OFF_W  = $clog2(STRB_W);
  localparam int unsigned IDX_W  = $clog2(NUM_REGS);
  localparam int unsigned UP_W   = ADDR_W - OFF_W;
  localparam int unsigned NUM_RW = NUM_REGS - NUM_RO;
  localparam int unsigned CNT_W  = 4;

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_e;

  state_e             state_q, state_d, phase_c;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               err_q, err_d;
  logic               wr_q, wr_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               pready_q, pready_d;
  logic               slverr_q, slverr_d;
  logic [DATA_W-1:0]  prdata_q, prdata_d;
  logic [DATA_W-1:0]  regs_q [NUM_RW];

  logic [UP_W-1:0]    upper_c;
  logic [IDX_W-1:0]   idx_dec_c;
  logic [IDX_W-1:0]   ro_slot_c;
  logic               dec_err_c;
  logic               commit_c;
  logic [DATA_W-1:0]  rd_val_c;
  logic               unused_prot_c;

  assign unused_prot_c = ^{prot[2], prot[0]};

  // Address decode for the transfer currently in its setup phase
  assign upper_c   = paddr[ADDR_W-1:OFF_W];
  assign idx_dec_c = paddr[OFF_W +: IDX_W];
  assign dec_err_c = (upper_c >= UP_W'(NUM_REGS))
                   || (|paddr[OFF_W-1:0])
                   || (pwrite && ({1'b0, idx_dec_c} >= (IDX_W+1)'(NUM_RW)))
                   || ((PROT_CHECK != 0) && prot[1]);

  // The setup phase is the idle cycle in which the requester presents psel without penable
  always_comb begin
    phase_c = state_q;
    if (state_q == IDLE && psel && !penable) phase_c = SETUP;
  end

  assign ro_slot_c = idx_d - IDX_W'(NUM_RW);

  always_comb begin
    rd_val_c = '0;
    if ({1'b0, idx_d} < (IDX_W+1)'(NUM_RW)) begin
      rd_val_c = regs_q[idx_d];
    end else if ({1'b0, idx_d} < (IDX_W+1)'(NUM_REGS)) begin
      rd_val_c = ro_data[32'(ro_slot_c)*DATA_W +: DATA_W];
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    err_d    = err_q;
    wr_d     = wr_q;
    idx_d    = idx_q;
    unique case (phase_c)
      SETUP: begin
        state_d = ACCESS;
        cnt_d   = '0;
        err_d   = dec_err_c;
        wr_d    = pwrite;
        idx_d   = idx_dec_c;
      end
      ACCESS: begin
        if (!psel) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q < CNT_W'(WAIT_CYCLES)) begin
          cnt_d = cnt_q + 1'b1;
        end else begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      end
      default: state_d = IDLE;
    endcase

    // Completion flags are registered so they land in the final ACCESS cycle
    pready_d = (state_d == ACCESS) && (cnt_d == CNT_W'(WAIT_CYCLES));
    slverr_d = pready_d && err_d;
    prdata_d = prdata_q;
    if (pready_d && !wr_d) prdata_d = rd_val_c;
    if (slverr_d) prdata_d = '0;
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      err_q    <= 1'b0;
      wr_q     <= 1'b0;
      idx_q    <= '0;
      pready_q <= 1'b0;
      slverr_q <= 1'b0;
      prdata_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      err_q    <= err_d;
      wr_q     <= wr_d;
      idx_q    <= idx_d;
      pready_q <= pready_d;
      slverr_q <= slverr_d;
      prdata_q <= prdata_d;
    end
  end

  assign commit_c = psel && penable && pready_q && pwrite && !err_q;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      for (int i = 0; i < NUM_RW; i++) regs_q[i] <= RESET_VAL;
    end else if (commit_c) begin
      for (int i = 0; i < NUM_RW; i++) begin
        if (idx_q == IDX_W'(i)) begin
          for (int b = 0; b < STRB_W; b++) begin
            if (pstrb[b]) regs_q[i][8*b +: 8] <= pwdata[8*b +: 8];
          end
        end
      end
    end
  end

  for (genvar g = 0; g < NUM_RW; g++) begin : g_reg_out
    assign reg_out[g*DATA_W +: DATA_W] = regs_q[g];
  end

  assign pready = pready_q;
  assign slverr = slverr_q;
  assign prdata = prdata_q;

endmodule

// File: tb/tb_apb_regfile_slave.sv
// Directed bench: three completers (0/3/5 wait states) on a shared APB bus, selected by psel.
module tb_apb_regfile_slave;

  localparam int unsigned N = 3;

  logic        clk = 1'b0;
  logic        nrst = 1'b1;
  logic [31:0] paddr = '0;
  logic [2:0]  prot = '0;
  logic [N-1:0] psel = '0;
  logic        penable = 1'b0;
  logic        pwrite = 1'b0;
  logic [31:0] pwdata = '0;
  logic [3:0]  pstrb = '0;
  logic [N-1:0] pready;
  logic [N-1:0] slverr;
  logic [31:0] prdata [N];
  logic [127:0] ro_data = {32'hC0DE0003, 32'hC0DE0002, 32'hC0DE0001, 32'hC0DE0000};
  logic [383:0] reg_out [N];

  int vectors = 0;
  int errors  = 0;
  int cyc     = 0;
  int bad_err = 0;

  logic [31:0] t_rdata;
  logic        t_err;
  int          t_setup;
  int          t_ready;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    for (int i = 0; i < N; i++) if (slverr[i] && !pready[i]) bad_err++;
  end

  apb_regfile_slave #(.WAIT_CYCLES(0), .PROT_CHECK(1), .RESET_VAL(32'hA5A5_0000)) u_a (
    .clk(clk), .nrst(nrst), .paddr(paddr), .prot(prot), .psel(psel[0]), .penable(penable),
    .pwrite(pwrite), .pwdata(pwdata), .pstrb(pstrb), .pready(pready[0]), .prdata(prdata[0]),
    .slverr(slverr[0]), .ro_data(ro_data), .reg_out(reg_out[0]));

  apb_regfile_slave #(.WAIT_CYCLES(3)) u_b (
    .clk(clk), .nrst(nrst), .paddr(paddr), .prot(prot), .psel(psel[1]), .penable(penable),
    .pwrite(pwrite), .pwdata(pwdata), .pstrb(pstrb), .pready(pready[1]), .prdata(prdata[1]),
    .slverr(slverr[1]), .ro_data(ro_data), .reg_out(reg_out[1]));

  apb_regfile_slave #(.WAIT_CYCLES(5)) u_c (
    .clk(clk), .nrst(nrst), .paddr(paddr), .prot(prot), .psel(psel[2]), .penable(penable),
    .pwrite(pwrite), .pwdata(pwdata), .pstrb(pstrb), .pready(pready[2]), .prdata(prdata[2]),
    .slverr(slverr[2]), .ro_data(ro_data), .reg_out(reg_out[2]));

  // One APB transfer starting now (just after an edge); returns just after the completion edge
  task automatic xfer(input int s, input logic [31:0] a, input logic w, input logic [31:0] d,
                      input logic [3:0] st, input logic [2:0] pr);
    int n;
    paddr = a; pwrite = w; pwdata = d; pstrb = st; prot = pr;
    psel = '0; psel[s] = 1'b1; penable = 1'b0;
    t_setup = cyc;
    @(posedge clk); #1;
    penable = 1'b1;
    n = 0;
    while (!pready[s] && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    vectors++;
    if (pready[s] !== 1'b1) begin
      errors++;
      $display("FAIL xfer_timeout dut=%0d addr=%h: pready=%b required 1", s, a, pready[s]);
    end
    t_ready = cyc;
    t_rdata = prdata[s];
    t_err   = slverr[s];
    @(posedge clk); #1;
    psel = '0; penable = 1'b0;
  endtask

  task automatic test_reset();
    #3 nrst = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    for (int i = 0; i < N; i++) begin
      vectors++;
      if ({pready[i], slverr[i], prdata[i]} !== 34'h0) begin
        errors++;
        $display("FAIL reset_outputs dut=%0d: pready=%b slverr=%b prdata=%h required 0/0/0",
                 i, pready[i], slverr[i], prdata[i]);
      end
    end
    for (int k = 0; k < 12; k++) begin
      vectors++;
      if (reg_out[0][k*32 +: 32] !== 32'hA5A5_0000) begin
        errors++;
        $display("FAIL reset_reg_out slot=%0d: got %h required a5a50000", k, reg_out[0][k*32 +: 32]);
      end
    end
    nrst = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_write_read();
    xfer(0, 32'h04, 1'b1, 32'hDEADBEEF, 4'hF, 3'b000);
    vectors++;
    if (t_err !== 1'b0 || (t_ready - t_setup) != 1) begin
      errors++;
      $display("FAIL wr_04: slverr=%b latency=%0d required 0/1", t_err, t_ready - t_setup);
    end
    xfer(0, 32'h04, 1'b0, 32'h0, 4'h0, 3'b000);
    vectors++;
    if (t_rdata !== 32'hDEADBEEF || t_err !== 1'b0 || (t_ready - t_setup) != 1) begin
      errors++;
      $display("FAIL rd_04: prdata=%h slverr=%b latency=%0d required deadbeef/0/1",
               t_rdata, t_err, t_ready - t_setup);
    end
    vectors++;
    if (reg_out[0][32 +: 32] !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL reg_out_slot1: got %h required deadbeef", reg_out[0][32 +: 32]);
    end
  endtask

  task automatic test_strobe();
    xfer(0, 32'h08, 1'b1, 32'hFFFFFFFF, 4'hF, 3'b000);
    xfer(0, 32'h08, 1'b1, 32'h11223344, 4'b0101, 3'b000);
    xfer(0, 32'h08, 1'b0, 32'h0, 4'h0, 3'b000);
    vectors++;
    if (t_rdata !== 32'hFF22FF44) begin
      errors++;
      $display("FAIL strobe_0101: prdata=%h required ff22ff44", t_rdata);
    end
    xfer(0, 32'h08, 1'b1, 32'h00000000, 4'h0, 3'b000);
    vectors++;
    if (t_err !== 1'b0) begin
      errors++;
      $display("FAIL zero_strobe_err: slverr=%b required 0", t_err);
    end
    xfer(0, 32'h08, 1'b0, 32'h0, 4'h0, 3'b000);
    vectors++;
    if (t_rdata !== 32'hFF22FF44) begin
      errors++;
      $display("FAIL zero_strobe_data: prdata=%h required ff22ff44", t_rdata);
    end
  endtask

  task automatic test_errors();
    xfer(0, 32'h40, 1'b0, 32'h0, 4'h0, 3'b000);
    vectors++;
    if (t_err !== 1'b1 || t_rdata !== 32'h0) begin
      errors++;
      $display("FAIL oob_read: slverr=%b prdata=%h required 1/0", t_err, t_rdata);
    end
    xfer(0, 32'h06, 1'b1, 32'h0, 4'hF, 3'b000);
    vectors++;
    if (t_err !== 1'b1) begin
      errors++;
      $display("FAIL misaligned_err: slverr=%b required 1", t_err);
    end
    xfer(0, 32'h04, 1'b0, 32'h0, 4'h0, 3'b000);
    vectors++;
    if (t_rdata !== 32'hDEADBEEF || t_err !== 1'b0) begin
      errors++;
      $display("FAIL misaligned_nowrite: prdata=%h slverr=%b required deadbeef/0", t_rdata, t_err);
    end
    xfer(0, 32'h30, 1'b1, 32'h12345678, 4'hF, 3'b000);
    vectors++;
    if (t_err !== 1'b1) begin
      errors++;
      $display("FAIL ro_write_err: slverr=%b required 1", t_err);
    end
    xfer(0, 32'h30, 1'b0, 32'h0, 4'h0, 3'b000);
    vectors++;
    if (t_rdata !== 32'hC0DE0000 || t_err !== 1'b0) begin
      errors++;
      $display("FAIL ro_read_slot0: prdata=%h slverr=%b required c0de0000/0", t_rdata, t_err);
    end
    xfer(0, 32'h3C, 1'b0, 32'h0, 4'h0, 3'b000);
    vectors++;
    if (t_rdata !== 32'hC0DE0003) begin
      errors++;
      $display("FAIL ro_read_slot3: prdata=%h required c0de0003", t_rdata);
    end
    xfer(0, 32'h04, 1'b0, 32'h0, 4'h0, 3'b010);
    vectors++;
    if (t_err !== 1'b1 || t_rdata !== 32'h0) begin
      errors++;
      $display("FAIL prot_err: slverr=%b prdata=%h required 1/0", t_err, t_rdata);
    end
    xfer(0, 32'h04, 1'b0, 32'h0, 4'h0, 3'b000);
    vectors++;
    if (t_err !== 1'b0 || t_rdata !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL prot_ok: slverr=%b prdata=%h required 0/deadbeef", t_err, t_rdata);
    end
  endtask

  task automatic test_back_to_back();
    int first_ready;
    xfer(1, 32'h0C, 1'b1, 32'hCAFEF00D, 4'hF, 3'b000);
    first_ready = t_ready;
    vectors++;
    if ((t_ready - t_setup) != 4 || t_err !== 1'b0) begin
      errors++;
      $display("FAIL wait3_latency: latency=%0d slverr=%b required 4/0", t_ready - t_setup, t_err);
    end
    xfer(1, 32'h0C, 1'b0, 32'h0, 4'h0, 3'b000);
    vectors++;
    if ((t_ready - first_ready) != 5) begin
      errors++;
      $display("FAIL b2b_spacing: cycles=%0d required 5", t_ready - first_ready);
    end
    vectors++;
    if (t_rdata !== 32'hCAFEF00D || t_err !== 1'b0) begin
      errors++;
      $display("FAIL b2b_raw: prdata=%h slverr=%b required cafef00d/0", t_rdata, t_err);
    end
  endtask

  task automatic test_abort();
    int seen;
    xfer(2, 32'h08, 1'b1, 32'h0000AAAA, 4'hF, 3'b000);
    paddr = 32'h08; pwrite = 1'b1; pwdata = 32'h00001234; pstrb = 4'hF; prot = 3'b000;
    psel = 3'b100; penable = 1'b0;
    @(posedge clk); #1;
    penable = 1'b1;
    @(posedge clk); #1;
    psel = '0; penable = 1'b0;
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      if (pready[2] || slverr[2]) seen++;
      @(posedge clk); #1;
    end
    vectors++;
    if (seen != 0) begin
      errors++;
      $display("FAIL abort_pready: cycles_with_pready_or_slverr=%0d required 0", seen);
    end
    vectors++;
    if (reg_out[2][64 +: 32] !== 32'h0000AAAA) begin
      errors++;
      $display("FAIL abort_nowrite: reg=%h required 0000aaaa", reg_out[2][64 +: 32]);
    end
    xfer(2, 32'h08, 1'b0, 32'h0, 4'h0, 3'b000);
    vectors++;
    if (t_rdata !== 32'h0000AAAA || (t_ready - t_setup) != 6) begin
      errors++;
      $display("FAIL abort_recover: prdata=%h latency=%0d required 0000aaaa/6",
               t_rdata, t_ready - t_setup);
    end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_strobe();
    test_errors();
    test_back_to_back();
    test_abort();
    @(posedge clk); #1;
    vectors++;
    if (bad_err != 0) begin
      errors++;
      $display("FAIL slverr_without_pready: count=%0d required 0", bad_err);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/apb_regfile_slave.md
# apb_regfile_slave

Parametrised APB4 completer that holds a bank of memory-mapped registers. It has configurable data width, register count, fixed wait states and per-byte write strobes. Address, alignment, read-only and protection violations are reported through `slverr`. It replaces the fixed-width `apb_slave` behind the same APB bus signals and sits between the APB interconnect and block-level control/status logic.

## Interface
- `DATA_W`, default 32, bus and register width; legal values are 32 or 64. `pstrb` is `DATA_W/8` bits.
- `ADDR_W`, default 32, `paddr` width.
- `NUM_REGS`, default 16, total register slots; legal range is 2..256.
- `NUM_RO`, default 4, top `NUM_RO` slots are read-only (indices `NUM_REGS-NUM_RO`..`NUM_REGS-1`); legal range is 0..`NUM_REGS-1`.
- `WAIT_CYCLES`, default 0, wait states inserted in every access; legal range is 0..15.
- `PROT_CHECK`, default 0. When 1, any access with `prot[1]`=1 (non-secure) errors.
- `RESET_VAL`, default 0, reset value of every RW register.
- `clk` input 1: single clock, rising edge.
- `nrst` input 1: asynchronous, active-low reset.
- `paddr` input `ADDR_W`: byte address.
- `prot` input 3: APB protection.
- `psel` input 1: select.
- `penable` input 1: access phase.
- `pwrite` input 1: 1 = write.
- `pwdata` input `DATA_W`: write data.
- `pstrb` input `DATA_W/8`: byte write strobes.
- `pready` output 1: transfer complete.
- `prdata` output `DATA_W`: read data, registered.
- `slverr` output 1: transfer error.
- `ro_data` input `NUM_RO*DATA_W`: hardware values returned for RO slots; slot k maps to bits [k*DATA_W +: DATA_W].
- `reg_out` output `(NUM_REGS-NUM_RO)*DATA_W`: current RW register contents, same packing.

## Operation
- Register index is `paddr >> log2(DATA_W/8)`. Misaligned means the low `log2(DATA_W/8)` address bits are nonzero.
- FSM states are IDLE, SETUP and ACCESS.
  - IDLE → SETUP when `psel`=1 and `penable`=0.
  - SETUP → ACCESS on the next cycle. The transfer is decoded and the error flag is latched here.
  - ACCESS holds while the wait counter is below `WAIT_CYCLES`, with `pready`=0.
  - ACCESS completes when the counter equals `WAIT_CYCLES`: `pready`=1 that cycle.
  - After completion, go to SETUP if `psel`=1 and `penable`=0 at the next edge (back-to-back transfer), otherwise go to IDLE.
- Error conditions, OR'ed together:
  - index ≥ `NUM_REGS`;
  - misaligned address;
  - write to an RO slot;
  - `PROT_CHECK`=1 and `prot[1]`=1.
- On an error, the write is suppressed, `prdata`=0, and `slverr`=1 in the completing cycle.
- Write commit happens on the edge where `psel`&`penable`&`pready`&!error. Byte i of the target register is updated iff `pstrb[i]`=1. An all-zero `pstrb` write completes without error and changes nothing.
- Read: `prdata` is loaded with the RW register or the `ro_data` slot, so it is valid in the cycle `pready`=1. `pstrb` is ignored on reads.
- Abort: if `psel` drops while in ACCESS, return to IDLE, clear the counter, perform no write, and keep `pready` and `slverr` at 0.
- A protocol violation (`penable`=1 seen in IDLE) is ignored: the FSM stays in IDLE.

## Timing
- Reset values: `pready`=0, `slverr`=0, `prdata`=0, every RW register = `RESET_VAL`, FSM=IDLE, counter=0.
- Reset asserted mid-transfer aborts the transfer immediately, with no write.
- Latency: SETUP at cycle T, first ACCESS at T+1, `pready` at T+1+`WAIT_CYCLES`.
- `pready` and `slverr` are 0 outside the completing ACCESS cycle. `slverr` is never high without `pready`.
- `prdata` holds its last value between reads and is 0 after any errored read.
- `reg_out` reflects a write in the cycle after the commit edge.
- A read immediately following a write to the same index returns the new value.
- The counter is 4 bits and resets to 0 at each SETUP.

## Test plan
- Reset with `RESET_VAL`=0xA5A5_0000 → `reg_out` is all slots 0xA5A5_0000; `pready`, `slverr` and `prdata` are all 0.
- `WAIT_CYCLES`=0: write 0xDEADBEEF to 0x04, then read 0x04 → `pready` is high in the cycle after SETUP, `prdata`=0xDEADBEEF, `slverr`=0.
- Write 0x11223344 with `pstrb`=0b0101 over 0xFFFFFFFF at 0x08 → reads back 0xFF22FF44.
- `WAIT_CYCLES`=3: a read starting SETUP at cycle 10 → `pready` only at cycle 14. A back-to-back second transfer completes at cycle 19.
- Error cases:
  - address 0x40 with `NUM_REGS`=16 → `slverr`=1, `prdata`=0;
  - address 0x06 → `slverr`=1, no write;
  - write to index 12 → `slverr`=1, register unchanged, and a read returns the `ro_data` slot 0 value;
  - `PROT_CHECK`=1 with `prot`=3'b010 → `slverr`=1.
- Abort: `WAIT_CYCLES`=5, drop `psel` during the 2nd ACCESS cycle of a write of 0x1234 → FSM returns to IDLE, the register is unchanged, and `pready` was never asserted.
